// File: rtl/dp_pkg.sv
// Shared opcode encodings, flag bit layout and opcode classification for the execute pipe.
package dp_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_LSH  = 4'd8;

  localparam int FLAGS_W = 5;
  localparam int FLG_L   = 0;
  localparam int FLG_Z   = 1;
  localparam int FLG_F   = 2;
  localparam int FLG_C   = 3;
  localparam int FLG_N   = 4;

  // Every defined opcode except CMP produces a register writeback; 9-15 are NOPs.
  function automatic logic op_writes(input logic [3:0] op);
    return (op <= OP_LSH) && (op != OP_CMP);
  endfunction
endpackage

// File: rtl/dp_regfile.sv
// NREGS x WIDTH register array: two async read ports, async debug port, one sync write port.
// Write lands on the clock edge; reads always show the array contents, never in-flight data.
module dp_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);
  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];
endmodule

// File: rtl/dp_exec_pipe.sv
// Two-stage execute unit: operands latched (with forwarding) on accept, ALU result and flags committed next edge.
// Accept-to-writeback 2 edges at 1 instr/cycle; hold freezes both stages and drops in_ready.
module dp_exec_pipe
  import dp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [AW-1:0]      rdest,
  input  logic [AW-1:0]      rsrc,
  input  logic [WIDTH-1:0]   imm,
  input  logic               use_imm,
  input  logic               hold,
  output logic               wb_valid,
  output logic [AW-1:0]      wb_addr,
  output logic [WIDTH-1:0]   wb_data,
  output logic [FLAGS_W-1:0] flags,
  input  logic [AW-1:0]      dbg_addr,
  output logic [WIDTH-1:0]   dbg_data
);
  logic               accept, retire;
  logic [WIDTH-1:0]   rf_a, rf_b;
  logic               ex_vld_q, ex_vld_d;
  logic [3:0]         ex_op_q, ex_op_d;
  logic [AW-1:0]      ex_rdest_q, ex_rdest_d;
  logic [WIDTH-1:0]   ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic [FLAGS_W-1:0] flags_q, flags_d, alu_flags;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_wr;
  logic [WIDTH:0]     sum;
  logic [3:0]         shamt;
  logic               wb_valid_q, wb_valid_d;
  logic [AW-1:0]      wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0]   wb_data_q, wb_data_d;

  dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .ra_addr  (rdest),
    .ra_data  (rf_a),
    .rb_addr  (rsrc),
    .rb_data  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (retire & alu_wr),
    .waddr    (ex_rdest_q),
    .wdata    (alu_res)
  );

  assign in_ready = ~hold & ~reset;
  assign accept   = in_valid & in_ready;
  assign retire   = ex_vld_q & ~hold;

  // flags_q already holds the result of the instruction ahead, so ADDC reads it directly.
  always_comb begin
    alu_res   = ex_a_q;
    alu_flags = flags_q;
    alu_wr    = op_writes(ex_op_q);
    sum       = '0;
    shamt     = '0;
    case (ex_op_q)
      OP_ADD, OP_ADDC: begin
        sum = {1'b0, ex_a_q} + {1'b0, ex_b_q}
            + {{WIDTH{1'b0}}, (ex_op_q == OP_ADDC) & flags_q[FLG_C]};
        alu_res = sum[WIDTH-1:0];
        alu_flags[FLG_C] = sum[WIDTH];
        alu_flags[FLG_F] = (ex_a_q[WIDTH-1] == ex_b_q[WIDTH-1]) & (alu_res[WIDTH-1] != ex_a_q[WIDTH-1]);
      end
      OP_SUB: begin
        sum = {1'b0, ex_a_q} - {1'b0, ex_b_q};
        alu_res = sum[WIDTH-1:0];
        alu_flags[FLG_C] = sum[WIDTH];
        alu_flags[FLG_F] = (ex_a_q[WIDTH-1] != ex_b_q[WIDTH-1]) & (alu_res[WIDTH-1] != ex_a_q[WIDTH-1]);
      end
      OP_CMP: begin
        alu_flags[FLG_Z] = (ex_a_q == ex_b_q);
        alu_flags[FLG_L] = (ex_a_q < ex_b_q);
        alu_flags[FLG_N] = ($signed(ex_a_q) < $signed(ex_b_q));
      end
      OP_AND: alu_res = ex_a_q & ex_b_q;
      OP_OR:  alu_res = ex_a_q | ex_b_q;
      OP_XOR: alu_res = ex_a_q ^ ex_b_q;
      OP_MOV: alu_res = ex_b_q;
      OP_LSH: begin
        shamt = ex_b_q[WIDTH-1] ? 4'(-ex_b_q) : ex_b_q[3:0];
        if (int'(shamt) >= WIDTH) alu_res = '0;
        else if (ex_b_q[WIDTH-1]) alu_res = ex_a_q >> shamt;
        else                      alu_res = ex_a_q << shamt;
      end
      default: ;
    endcase
    if (alu_wr && ex_op_q != OP_MOV) begin
      alu_flags[FLG_Z] = (alu_res == '0);
      alu_flags[FLG_N] = alu_res[WIDTH-1];
    end
  end

  always_comb begin
    ex_vld_d   = ex_vld_q;
    ex_op_d    = ex_op_q;
    ex_rdest_d = ex_rdest_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    flags_d    = flags_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (!hold) begin
      ex_vld_d = accept;
      if (accept) begin
        ex_op_d    = opcode;
        ex_rdest_d = rdest;
        // The instruction retiring on this same edge supersedes the array value.
        ex_a_d = (ex_vld_q & alu_wr & (ex_rdest_q == rdest)) ? alu_res : rf_a;
        ex_b_d = use_imm ? imm : ((ex_vld_q & alu_wr & (ex_rdest_q == rsrc)) ? alu_res : rf_b);
      end
    end
    if (retire) begin
      flags_d = alu_flags;
      if (alu_wr) begin
        wb_valid_d = 1'b1;
        wb_addr_d  = ex_rdest_q;
        wb_data_d  = alu_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_vld_q   <= 1'b0;
      ex_op_q    <= '0;
      ex_rdest_q <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      flags_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      ex_vld_q   <= ex_vld_d;
      ex_op_q    <= ex_op_d;
      ex_rdest_q <= ex_rdest_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      flags_q    <= flags_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign flags    = flags_q;
endmodule

// File: tb/tb_dp_exec_pipe.sv
// Randomised and directed bench for dp_exec_pipe against a sequential architectural reference model.
module tb_dp_exec_pipe;
  import dp_pkg::*;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, use_imm, hold, wb_valid;
  logic [3:0]    opcode;
  logic [AW-1:0] rdest, rsrc, wb_addr, dbg_addr;
  logic [W-1:0]  imm, wb_data, dbg_data;
  logic [4:0]    flags;

  always #5 clk = ~clk;

  dp_exec_pipe #(.WIDTH(W), .NREGS(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rdest(rdest), .rsrc(rsrc), .imm(imm), .use_imm(use_imm),
    .hold(hold), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: m_* is program-order state, c_* is what the architecture shows after retirement.
  int unsigned m_reg[16], c_reg[16];
  int unsigned m_flags, c_flags;
  bit          p_vld, p_wr;
  int unsigned p_addr, p_data, p_flags;
  bit          n_wr;
  int unsigned n_res;

  function automatic int sgn(input int unsigned v);
    return (v >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic int unsigned setf(input int unsigned f, input int idx, input bit v);
    return v ? (f | (32'd1 << idx)) : (f & ~(32'd1 << idx));
  endfunction

  task automatic model_exec(input int op, input int rd, input int rs, input int unsigned im, input bit ui);
    int unsigned a, b, s, f;
    int ss, amt;
    a = m_reg[rd];
    b = ui ? im : m_reg[rs];
    f = m_flags;
    n_wr = 1'b1;
    n_res = 0;
    case (op)
      0, 1: begin
        s  = a + b + ((op == 1) ? ((f >> FLG_C) & 1) : 0);
        ss = sgn(a) + sgn(b) + ((op == 1) ? int'((f >> FLG_C) & 1) : 0);
        n_res = s % 65536;
        f = setf(f, FLG_C, s > 65535);
        f = setf(f, FLG_F, ss > 32767 || ss < -32768);
      end
      2: begin
        n_res = (a + 65536 - b) % 65536;
        ss = sgn(a) - sgn(b);
        f = setf(f, FLG_C, a < b);
        f = setf(f, FLG_F, ss > 32767 || ss < -32768);
      end
      3: begin
        n_wr = 1'b0;
        f = setf(f, FLG_Z, a == b);
        f = setf(f, FLG_L, a < b);
        f = setf(f, FLG_N, sgn(a) < sgn(b));
      end
      4: n_res = a & b;
      5: n_res = a | b;
      6: n_res = a ^ b;
      7: n_res = b;
      8: begin
        if (sgn(b) < 0) begin
          amt = (-sgn(b)) % 16;
          n_res = a / (32'd1 << amt);
        end else begin
          amt = int'(b % 16);
          n_res = (a * (32'd1 << amt)) % 65536;
        end
        if (amt >= 16) n_res = 0;
      end
      default: n_wr = 1'b0;
    endcase
    if (n_wr && op != 7) begin
      f = setf(f, FLG_Z, n_res == 0);
      f = setf(f, FLG_N, n_res >= 32768);
    end
    m_flags = f;
    if (n_wr) m_reg[rd] = n_res;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_reg[i] = 0;
      c_reg[i] = 0;
    end
    m_flags = 0;
    c_flags = 0;
    p_vld   = 1'b0;
  endtask

  // One clock: drive, check combinational outputs, advance, check what the edge produced.
  task automatic cycle(input bit v, input int op, input int rd, input int rs,
                       input int unsigned im, input bit ui, input bit h);
    bit ret, acc;
    in_valid = v;
    opcode   = op[3:0];
    rdest    = rd[3:0];
    rsrc     = rs[3:0];
    imm      = im[15:0];
    use_imm  = ui;
    hold     = h;
    dbg_addr = 4'($urandom_range(0, 15));
    #1;
    chk("in_ready", in_ready, !h);
    chk("dbg_data", dbg_data, c_reg[dbg_addr]);
    ret = p_vld && !h;
    acc = v && !h;
    if (acc) model_exec(op, rd, rs, im, ui);
    @(posedge clk);
    #1;
    if (ret) begin
      chk("wb_valid", wb_valid, p_wr);
      if (p_wr) begin
        chk("wb_addr", wb_addr, p_addr);
        chk("wb_data", wb_data, p_data);
        c_reg[p_addr] = p_data;
      end
      c_flags = p_flags;
      p_vld = 1'b0;
    end else begin
      chk("wb_idle", wb_valid, 0);
    end
    chk("flags", flags, c_flags);
    if (acc) begin
      p_vld   = 1'b1;
      p_wr    = n_wr;
      p_addr  = rd;
      p_data  = n_res;
      p_flags = m_flags;
    end
  endtask

  task automatic idle();
    cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    hold     = 1'b0;
    dbg_addr = 4'd3;
    #1;
    chk("rst_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    model_clear();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_r3", dbg_data, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready_high", in_ready, 1);
  endtask

  task automatic chk_reg(input string tag, input int addr, input int unsigned exp);
    dbg_addr = addr[3:0];
    #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; hold = 1'b0; opcode = '0; rdest = '0; rsrc = '0;
    imm = '0; use_imm = 1'b0; dbg_addr = '0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Reset clears a committed register and discards an in-flight one.
    cycle(1, OP_MOV, 3, 0, 'h1234, 1, 0);
    idle();
    chk_reg("pre_rst_r3", 3, 'h1234);
    cycle(1, OP_MOV, 4, 0, 'h5555, 1, 0);
    do_reset();
    chk_reg("rst_inflight_r4", 4, 0);
    idle();
    chk("rst_no_wb", wb_valid, 0);

    // Forwarding on back-to-back dependent instructions.
    cycle(1, OP_MOV, 1, 0, 5, 1, 0);
    cycle(1, OP_ADD, 1, 0, 7, 1, 0);
    cycle(1, OP_ADD, 2, 1, 0, 0, 0);
    idle(); idle();
    chk_reg("fwd_r1", 1, 'h000C);
    chk_reg("fwd_r2", 2, 'h000C);

    // Carry chain into ADDC.
    do_reset();
    cycle(1, OP_MOV, 1, 0, 'hFFFF, 1, 0);
    cycle(1, OP_ADD, 1, 0, 1, 1, 0);
    cycle(1, OP_ADDC, 2, 0, 0, 1, 0);
    chk("carry_c", flags[FLG_C], 1);
    chk("carry_z", flags[FLG_Z], 1);
    idle(); idle();
    chk_reg("carry_r1", 1, 0);
    chk_reg("carry_r2", 2, 1);

    // Signed overflow then CMP.
    do_reset();
    cycle(1, OP_MOV, 1, 0, 'h7FFF, 1, 0);
    cycle(1, OP_ADD, 1, 0, 1, 1, 0);
    cycle(1, OP_CMP, 1, 0, 1, 1, 0);
    chk("ovf_f", flags[FLG_F], 1);
    chk("ovf_n", flags[FLG_N], 1);
    idle();
    chk("cmp_l", flags[FLG_L], 0);
    chk("cmp_n", flags[FLG_N], 1);
    chk_reg("cmp_r1", 1, 'h8000);

    // Hold with an ADD in the execute stage.
    do_reset();
    cycle(1, OP_MOV, 1, 0, 3, 1, 0);
    cycle(1, OP_ADD, 1, 0, 4, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, OP_MOV, 5, 0, 9, 1, 1);
    idle();
    chk("hold_release_wb", wb_valid, 1);
    chk_reg("hold_r1", 1, 7);

    // Reserved opcode and shifts.
    do_reset();
    cycle(1, OP_MOV, 1, 0, 1, 1, 0);
    cycle(1, OP_CMP, 1, 0, 5, 1, 0);
    cycle(1, 12, 1, 0, 0, 1, 0);
    cycle(1, OP_LSH, 1, 0, 4, 1, 0);
    chk("rsv_no_wb", wb_valid, 0);
    chk("rsv_flags_l", flags[FLG_L], 1);
    cycle(1, OP_MOV, 2, 0, 'h8000, 1, 0);
    cycle(1, OP_LSH, 2, 0, 'hFFFF, 1, 0);
    idle(); idle();
    chk_reg("lsh_left", 1, 'h0010);
    chk_reg("lsh_right", 2, 'h4000);

    // Random traffic with holds, bubbles and occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 11)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 32'h0000_FFFF : $urandom_range(0, 65535),
            $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
    end
    idle(); idle();
    for (int i = 0; i < 16; i++) chk_reg("final_reg", i, c_reg[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
